// File: rtl/lock_pkg.sv
// Shared types for the canal lock operator: FSM states, BCD level type and side selects.
package lock_pkg;

    // {ones, tenths} BCD; plain unsigned compare orders levels correctly.
    typedef logic [7:0] bcd_lvl_t;

    typedef enum logic [3:0] {
        StIdle,
        StEqA,
        StOpenA,
        StXferIn,
        StCloseA,
        StEqB,
        StOpenB,
        StXferOut,
        StCloseB,
        StFault
    } lock_state_e;

    // Which physical side plays the role of side A for the current passage.
    localparam logic SideOuter = 1'b0;
    localparam logic SideInner = 1'b1;

endpackage

// File: rtl/op_timer.sv
// Loadable down-counter shared by the gap, dwell and timeout timing; done_o is high at zero.
module op_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lock_operator.sv
// Canal lock sequencer: equalises the chamber to each side, opens ports, times the transfer.
// Define LOCK_OPERATOR_TIMEOUT_EN to add the per-step water timeout and the sticky FAULT state.
module lock_operator
    import lock_pkg::*;
#(
    parameter int unsigned DWELL_CYC = 8,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned TMO_CYC   = 64
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     req_in,
    input  logic     req_out,
    input  bcd_lvl_t inner_lvl,
    input  bcd_lvl_t lock_lvl,
    input  bcd_lvl_t outer_lvl,
    output logic     arrive,
    output logic     depart,
    output logic     outer_port,
    output logic     inner_port,
    output logic     raise,
    output logic     lower,
    output logic     busy,
    output logic     fault
);

    localparam int unsigned StepMax = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int unsigned CntMax  = (TMO_CYC > StepMax) ? TMO_CYC : StepMax;
    localparam int unsigned TimerW  = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [TimerW-1:0] GapLoad   = TimerW'(GAP_CYC - 1);
    localparam logic [TimerW-1:0] DwellLoad = TimerW'(DWELL_CYC - 1);

    lock_state_e       state_q, state_d;
    logic              side_q, side_d;
    bcd_lvl_t          tgt_a, tgt_b, eq_tgt;
    logic              step_load, step_done, tmo;
    logic [TimerW-1:0] step_val;
    logic              port_a, port_b;

    // Targets stay live: a side level moving mid-step retargets the equalisation.
    assign tgt_a  = (side_q == SideOuter) ? outer_lvl : inner_lvl;
    assign tgt_b  = (side_q == SideOuter) ? inner_lvl : outer_lvl;
    assign eq_tgt = (state_q == StEqB) ? tgt_b : tgt_a;

    always_comb begin
        state_d   = state_q;
        side_d    = side_q;
        step_load = 1'b0;
        step_val  = GapLoad;
        raise     = 1'b0;
        lower     = 1'b0;
        arrive    = 1'b0;
        depart    = 1'b0;
        port_a    = 1'b0;
        port_b    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_in) begin
                    side_d  = SideOuter;
                    state_d = StEqA;
                end else if (req_out) begin
                    side_d  = SideInner;
                    state_d = StEqA;
                end
            end
            StEqA, StEqB: begin
                if (lock_lvl == eq_tgt) begin
                    state_d = (state_q == StEqA) ? StOpenA : StOpenB;
                end else if (tmo) begin
                    state_d = StFault;
                end else if (step_done) begin
                    raise     = (lock_lvl < eq_tgt);
                    lower     = (lock_lvl > eq_tgt);
                    step_load = 1'b1;
                end
            end
            StOpenA: begin
                port_a    = 1'b1;
                step_load = 1'b1;
                step_val  = DwellLoad;
                state_d   = StXferIn;
            end
            StXferIn: begin
                port_a = 1'b1;
                arrive = 1'b1;
                if (step_done) begin
                    state_d = StCloseA;
                end
            end
            StCloseA: begin
                port_a  = 1'b1;
                state_d = StEqB;
            end
            StOpenB: begin
                port_b    = 1'b1;
                step_load = 1'b1;
                step_val  = DwellLoad;
                state_d   = StXferOut;
            end
            StXferOut: begin
                port_b = 1'b1;
                depart = 1'b1;
                if (step_done) begin
                    state_d = StCloseB;
                end
            end
            StCloseB: begin
                port_b  = 1'b1;
                state_d = StIdle;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            side_q  <= SideOuter;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
        end
    end

    op_timer #(
        .Width(TimerW)
    ) u_step_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .load_i    (step_load),
        .load_val_i(step_val),
        .done_o    (step_done)
    );

`ifdef LOCK_OPERATOR_TIMEOUT_EN
    localparam logic [TimerW-1:0] TmoLoad = TimerW'(TMO_CYC - 1);

    bcd_lvl_t lvl_prev_q;
    logic     tmo_load, tmo_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_prev_q <= '0;
        end else begin
            lvl_prev_q <= lock_lvl;
        end
    end

    // Rearm outside equalisation and on every observed chamber level change.
    assign tmo_load = !(state_q inside {StEqA, StEqB}) || (lock_lvl != lvl_prev_q);

    op_timer #(
        .Width(TimerW)
    ) u_tmo_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .load_i    (tmo_load),
        .load_val_i(TmoLoad),
        .done_o    (tmo_done)
    );

    assign tmo   = tmo_done && !tmo_load;
    assign fault = (state_q == StFault);
`else
    assign tmo   = 1'b0;
    assign fault = 1'b0;
`endif

    assign outer_port = (port_a && (side_q == SideOuter)) || (port_b && (side_q == SideInner));
    assign inner_port = (port_a && (side_q == SideInner)) || (port_b && (side_q == SideOuter));
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lock_operator.sv
// Self-checking bench for lock_operator: directed scenarios plus random trips against a chamber model.
module tb_lock_operator;
    import lock_pkg::*;

    localparam int unsigned DWELL = 8;
    localparam int unsigned GAP   = 4;
    localparam int unsigned TMO   = 64;

    logic     clk = 1'b0;
    logic     reset;
    logic     req_in, req_out;
    bcd_lvl_t inner_lvl, lock_lvl, outer_lvl;
    logic     arrive, depart, outer_port, inner_port, raise, lower, busy, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_operator #(
        .DWELL_CYC(DWELL),
        .GAP_CYC  (GAP),
        .TMO_CYC  (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .req_out   (req_out),
        .inner_lvl (inner_lvl),
        .lock_lvl  (lock_lvl),
        .outer_lvl (outer_lvl),
        .arrive    (arrive),
        .depart    (depart),
        .outer_port(outer_port),
        .inner_port(inner_port),
        .raise     (raise),
        .lower     (lower),
        .busy      (busy),
        .fault     (fault)
    );

    // Chamber model: level in tenths, moved one step per observed pulse unless frozen.
    int lock_t;
    bit freeze;
    // Per-trip observations.
    int cyc_idx, n_raise, n_lower, n_arrive, n_depart, n_outer, n_inner;
    int first_port, first_port_idx, first_busy_idx, first_fault_idx, last_pulse, fault_pulse;
    int excl_viol = 0;
    int gap_viol  = 0;
    bit obs_busy, obs_fault;

    function automatic bcd_lvl_t to_bcd(input int t);
        logic [3:0] ones, tenths;
        ones   = 4'(t / 10);
        tenths = 4'(t % 10);
        return {ones, tenths};
    endfunction

    function automatic int exp_raises(input int l, input int a, input int b);
        return ((a > l) ? a - l : 0) + ((b > a) ? b - a : 0);
    endfunction

    function automatic int exp_lowers(input int l, input int a, input int b);
        return ((l > a) ? l - a : 0) + ((a > b) ? a - b : 0);
    endfunction

    task automatic set_levels(input int o, input int l, input int i);
        outer_lvl = to_bcd(o);
        inner_lvl = to_bcd(i);
        lock_t    = l;
        lock_lvl  = to_bcd(l);
    endtask

    task automatic begin_trip();
        cyc_idx = 0; n_raise = 0; n_lower = 0; n_arrive = 0; n_depart = 0;
        n_outer = 0; n_inner = 0; first_port = 0; first_port_idx = -1;
        first_busy_idx = -1; first_fault_idx = -1; last_pulse = -1; fault_pulse = 0;
    endtask

    // One clock: observe at negedge, let the chamber react just after the posedge.
    task automatic cycle();
        bit pr, pl;
        @(negedge clk);
        cyc_idx++;
        obs_busy  = busy;
        obs_fault = fault;
        pr = raise;
        pl = lower;
        if (raise && lower) excl_viol++;
        if ((raise || lower) && (outer_port || inner_port)) excl_viol++;
        if (outer_port && inner_port) excl_viol++;
        if (raise || lower) begin
            if (last_pulse >= 0 && (cyc_idx - last_pulse) < int'(GAP)) gap_viol++;
            last_pulse = cyc_idx;
            if (fault) fault_pulse++;
        end
        if (raise) n_raise++;
        if (lower) n_lower++;
        if (arrive) n_arrive++;
        if (depart) n_depart++;
        if (outer_port) n_outer++;
        if (inner_port) n_inner++;
        if (first_port == 0 && outer_port) begin first_port = 1; first_port_idx = cyc_idx; end
        if (first_port == 0 && inner_port) begin first_port = 2; first_port_idx = cyc_idx; end
        if (busy && first_busy_idx < 0) first_busy_idx = cyc_idx;
        if (fault && first_fault_idx < 0) first_fault_idx = cyc_idx;
        @(posedge clk);
        #1;
        if (!freeze) begin
            if (pr) lock_t++;
            if (pl) lock_t--;
            lock_lvl = to_bcd(lock_t);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            cycle();
            if (obs_busy) seen = 1'b1;
            else if (seen) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++;
        if ({arrive, depart, outer_port, inner_port, raise, lower, busy, fault} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000",
                     {arrive, depart, outer_port, inner_port, raise, lower, busy, fault});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        cycle();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy got %b want 0", obs_busy);
        end
    endtask

    task automatic test_full_trip();
        bit ok;
        set_levels(35, 30, 10);
        begin_trip();
        req_in = 1'b1;
        cycle();
        req_in = 1'b0;
        wait_idle(2000, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", ok); end
        checks++;
        if (n_raise != 5) begin errors++; $display("FAIL full_raise got %0d want 5", n_raise); end
        checks++;
        if (n_lower != 25) begin errors++; $display("FAIL full_lower got %0d want 25", n_lower); end
        checks++;
        if (n_arrive != int'(DWELL) || n_depart != int'(DWELL)) begin
            errors++;
            $display("FAIL full_dwell got arrive %0d depart %0d want %0d", n_arrive, n_depart, DWELL);
        end
        checks++;
        if (n_outer != int'(DWELL) + 2 || n_inner != int'(DWELL) + 2) begin
            errors++;
            $display("FAIL full_ports got outer %0d inner %0d want %0d", n_outer, n_inner, DWELL + 2);
        end
        checks++;
        if (first_port != 1) begin errors++; $display("FAIL full_order got %0d want 1", first_port); end
        checks++;
        if (lock_t != 10) begin errors++; $display("FAIL full_end_lvl got %0d want 10", lock_t); end
        checks++;
        if (gap_viol != 0) begin errors++; $display("FAIL full_gap got %0d want 0", gap_viol); end
    endtask

    task automatic test_both_req();
        bit ok;
        set_levels(20, 20, 23);
        begin_trip();
        req_in  = 1'b1;
        req_out = 1'b1;
        cycle();
        req_in = 1'b0;
        wait_idle(2000, ok);
        checks++;
        if (!ok || first_port != 1 || n_raise != 3 || n_lower != 0) begin
            errors++;
            $display("FAIL both_first got done %b port %0d raise %0d lower %0d want 1 1 3 0",
                     ok, first_port, n_raise, n_lower);
        end
        begin_trip();
        req_out = 1'b0;
        wait_idle(2000, ok);
        checks++;
        if (first_busy_idx != 1) begin
            errors++; $display("FAIL both_restart got busy at %0d want 1", first_busy_idx);
        end
        checks++;
        if (!ok || first_port != 2 || n_raise != 0 || n_lower != 3) begin
            errors++;
            $display("FAIL both_second got done %b port %0d raise %0d lower %0d want 1 2 0 3",
                     ok, first_port, n_raise, n_lower);
        end
    endtask

    task automatic test_equal_levels();
        bit ok;
        set_levels(50, 50, 50);
        begin_trip();
        req_in = 1'b1;
        cycle();
        req_in = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (n_raise + n_lower != 0) begin
            errors++; $display("FAIL equal_pulses got %0d want 0", n_raise + n_lower);
        end
        checks++;
        // Request seen in cycle 1, port open two clocks later.
        if (first_port != 1 || first_port_idx != 3) begin
            errors++;
            $display("FAIL equal_port got side %0d at %0d want side 1 at 3", first_port, first_port_idx);
        end
    endtask

    task automatic test_reset_mid_xfer();
        set_levels(50, 50, 50);
        begin_trip();
        req_in = 1'b1;
        cycle();
        req_in = 1'b0;
        for (int k = 0; k < 30 && n_arrive == 0; k++) cycle();
        checks++;
        if (arrive !== 1'b1 || outer_port !== 1'b1) begin
            errors++; $display("FAIL midreset_pre got arrive %b port %b want 1 1", arrive, outer_port);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({arrive, depart, outer_port, inner_port, raise, lower, fault} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs got %b want 0000000",
                     {arrive, depart, outer_port, inner_port, raise, lower, fault});
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        #1 reset = 1'b1;
    endtask

    task automatic test_timeout();
        set_levels(40, 20, 40);
        freeze = 1'b1;
        begin_trip();
        req_in = 1'b1;
        cycle();
        req_in = 1'b0;
        for (int k = 1; k < 100; k++) cycle();
`ifdef LOCK_OPERATOR_TIMEOUT_EN
        checks++;
        if (first_fault_idx - 2 != int'(TMO) || obs_fault !== 1'b1) begin
            errors++;
            $display("FAIL tmo_fault got at %0d now %b want at %0d now 1",
                     first_fault_idx - 2, obs_fault, TMO);
        end
        checks++;
        if (n_raise != int'((TMO + GAP - 1) / GAP) || fault_pulse != 0) begin
            errors++;
            $display("FAIL tmo_pulses got %0d after_fault %0d want %0d 0",
                     n_raise, fault_pulse, (TMO + GAP - 1) / GAP);
        end
`else
        checks++;
        if (first_fault_idx != -1) begin
            errors++; $display("FAIL tmo_fault got at %0d want never", first_fault_idx);
        end
        checks++;
        if (n_raise != (99 + int'(GAP) - 1) / int'(GAP) || n_lower != 0) begin
            errors++;
            $display("FAIL tmo_pulses got raise %0d lower %0d want %0d 0",
                     n_raise, n_lower, (99 + GAP - 1) / GAP);
        end
`endif
        #1 reset = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_clear got fault %b busy %b want 0 0", fault, busy);
        end
        #1 reset = 1'b1;
        freeze = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int o, l, i, mode, ta, tb, er, el, ep;
        for (int t = 0; t < 24; t++) begin
            o    = int'($urandom_range(0, 99));
            l    = int'($urandom_range(0, 99));
            i    = int'($urandom_range(0, 99));
            mode = int'($urandom_range(0, 2));
            ta   = (mode == 1) ? i : o;
            tb   = (mode == 1) ? o : i;
            ep   = (mode == 1) ? 2 : 1;
            er   = exp_raises(l, ta, tb);
            el   = exp_lowers(l, ta, tb);
            set_levels(o, l, i);
            begin_trip();
            req_in  = (mode != 1);
            req_out = (mode != 0);
            cycle();
            req_in  = 1'b0;
            req_out = 1'b0;
            wait_idle(3000, ok);
            checks++;
            if (!ok || n_raise != er || n_lower != el) begin
                errors++;
                $display("FAIL rand_pulses[%0d] got done %b raise %0d lower %0d want 1 %0d %0d",
                         t, ok, n_raise, n_lower, er, el);
            end
            checks++;
            if (n_arrive != int'(DWELL) || n_depart != int'(DWELL) || first_port != ep) begin
                errors++;
                $display("FAIL rand_xfer[%0d] got arrive %0d depart %0d port %0d want %0d %0d %0d",
                         t, n_arrive, n_depart, first_port, DWELL, DWELL, ep);
            end
            checks++;
            if (lock_t != tb) begin
                errors++; $display("FAIL rand_end_lvl[%0d] got %0d want %0d", t, lock_t, tb);
            end
        end
        checks++;
        if (excl_viol != 0) begin
            errors++; $display("FAIL exclusivity got %0d violations want 0", excl_viol);
        end
        checks++;
        if (gap_viol != 0) begin
            errors++; $display("FAIL pulse_gap got %0d violations want 0", gap_viol);
        end
    endtask

    initial begin
        reset   = 1'b1;
        req_in  = 1'b0;
        req_out = 1'b0;
        freeze  = 1'b0;
        set_levels(0, 0, 0);
        begin_trip();
        test_reset();
        test_full_trip();
        test_both_req();
        test_equal_levels();
        test_reset_mid_xfer();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_operator.md
LOCK_OPERATOR -- requirements
Module: lock_operator

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 8, meaning cycles a port stays open with arrive/depart asserted.
REQ-002 SHALL have parameter GAP_CYC, default 4, meaning minimum cycles between water-step pulses.
REQ-003 SHALL have parameter TMO_CYC, default 64, meaning cycles allowed per water step before fault.
REQ-004 SHALL have ports as follows; clock and reset first.
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- req_in  in  1  gondola at outer side requests passage inward.
- req_out  in  1  gondola at inner side requests passage outward.
- inner_lvl  in  8  BCD water level {ones,tenths}, inner side.
- lock_lvl  in  8  BCD water level {ones,tenths}, lock chamber.
- outer_lvl  in  8  BCD water level {ones,tenths}, outer side.
- arrive  out  1  level; gondola entering chamber.
- depart  out  1  level; gondola leaving chamber.
- outer_port  out  1  level; outer port open.
- inner_port  out  1  level; inner port open.
- raise  out  1  one-cycle pulse; raise chamber one step.
- lower  out  1  one-cycle pulse; lower chamber one step.
- busy  out  1  high whenever the state is not IDLE.
- fault  out  1  sticky step-timeout flag.

Function
REQ-005 SHALL compare BCD levels as 8-bit unsigned values; {ones,tenths} ordering makes this exact.
REQ-006 SHALL implement these states: IDLE, EQ_A, OPEN_A, XFER_IN, CLOSE_A, EQ_B, OPEN_B, XFER_OUT, CLOSE_B, FAULT.
REQ-007 SHALL, in IDLE, latch direction: req_in → side A=outer, B=inner; else req_out → A=inner, B=outer; when both requests are set in one cycle, req_in wins.
REQ-008 SHALL, in EQ_A/EQ_B: if lock_lvl < target, issue a raise pulse; if lock_lvl > target, issue a lower pulse; pulses SHALL be at least GAP_CYC cycles apart; exit the state on the first cycle lock_lvl == target.
REQ-009 SHALL never assert raise and lower in the same cycle, and SHALL never pulse either while any port is open.
REQ-010 SHALL assert side-A port in OPEN_A, XFER_IN, CLOSE_A entry; side-B port in OPEN_B, XFER_OUT; never both ports in the same cycle.
REQ-011 SHALL hold arrive high for exactly DWELL_CYC cycles in XFER_IN, and depart high for exactly DWELL_CYC cycles in XFER_OUT.
REQ-012 SHALL deassert the port one cycle after dwell ends (CLOSE state lasts 1 cycle); CLOSE_B SHALL return to IDLE.
REQ-013 SHALL ignore requests while busy; a request still held on return to IDLE SHALL start a new cycle the next clock.
REQ-014 SHALL skip pulsing when already equal: EQ with equal levels SHALL exit after 1 cycle.
REQ-015 SHALL keep outer_lvl/inner_lvl targets live, not latched.

Reset
REQ-016 SHALL, on reset low, immediately drive all outputs to 0 and the state to IDLE, including mid-operation with a port open; fault SHALL clear.

Configuration
REQ-017 SHALL, with LOCK_OPERATOR_TIMEOUT_EN defined, count cycles since the last level change in EQ states and enter FAULT once the count reaches TMO_CYC; fault=1 and all ports/pulses stay 0 until reset.
REQ-018 SHALL, without the macro, have no timeout counter; EQ states wait indefinitely, and fault is tied to 0.

Structure
REQ-019 SHALL place the state enum, the bcd_lvl_t (8-bit) typedef, and the side-select constants in shared package lock_pkg.
REQ-020 SHALL use one sub-module, op_timer (load/count-down/done), reused for gap, dwell, and timeout counts.

Verification
REQ-021 SHALL cover these directed scenarios:
- req_in, outer=3.5, lock=3.0, inner=1.0 → 5 raise pulses ≥4 cycles apart, outer_port up, arrive 8 cycles, then 25 lower pulses, inner_port, depart 8 cycles, IDLE.
- req_in and req_out in the same cycle → outer side served first; inner request is served after return to IDLE.
- lock_lvl already equal to outer_lvl → no raise/lower pulses; outer_port rises 2 cycles after req_in.
- reset low during XFER_IN → all outputs 0 in the same cycle, busy=0.
- Macro on, lock_lvl frozen at 2.0, target 4.0 → fault=1 at 64 cycles, no further pulses; macro off → pulses continue and fault stays 0.
- Random request and level stimulus → assertions for REQ-009 and REQ-010 never fire.
